// File: rtl/lcd_screen_writer.sv
// Streams a 2x16 character buffer to an HD44780-style LCD as 34 bytes
// (two DDRAM address commands plus 32 characters), split into 4-bit nibbles.
module lcd_screen_writer #(
    parameter int FREQ     = 50000000,
    parameter int T_NIBBLE = FREQ/1000000*10,
    parameter int T_BYTE   = FREQ/1000000*53
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        initDone,
    input  logic        refresh,
    output logic [4:0]  char_addr,
    input  logic [7:0]  char_data,
    output logic        sendCommand,
    output logic [3:0]  command,
    output logic [20:0] commandDelay,
    output logic        read_busy,
    output logic        mode4bit,
    output logic        LCD_RS,
    input  logic        commandDone,
    output logic        busy,
    output logic        frameDone
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND_HI,
        WAIT_HI,
        SEND_LO,
        WAIT_LO
    } state_t;

    localparam logic [20:0] T_NIBBLE_C = 21'(T_NIBBLE);
    localparam logic [20:0] T_BYTE_C   = 21'(T_BYTE);
    localparam logic [5:0]  LINE2_IDX  = 6'd17;
    localparam logic [5:0]  LAST_IDX   = 6'd33;

    state_t      state_q, state_d;
    logic        ready_q, ready_d;
    logic        pending_q, pending_d;
    logic [5:0]  byteIdx_q, byteIdx_d;
    logic [7:0]  byte_q, byte_d;
    logic [4:0]  charAddr_q, charAddr_d;
    logic        sendCommand_q, sendCommand_d;
    logic [3:0]  command_q, command_d;
    logic [20:0] cmdDelay_q, cmdDelay_d;
    logic        readBusy_q, readBusy_d;
    logic        rs_q, rs_d;
    logic        busy_q, busy_d;
    logic        frameDone_q, frameDone_d;
    logic        mode4bit_q;

    logic [7:0]  srcByte;
    logic        srcIsChar;

    // Byte 0 and byte 17 are the line-1 / line-2 DDRAM address commands.
    always_comb begin
        srcByte   = char_data;
        srcIsChar = 1'b1;
        if (byteIdx_q == 6'd0) begin
            srcByte   = 8'h80;
            srcIsChar = 1'b0;
        end else if (byteIdx_q == LINE2_IDX) begin
            srcByte   = 8'hC0;
            srcIsChar = 1'b0;
        end
    end

    always_comb begin
        state_d       = state_q;
        ready_d       = ready_q | initDone;
        pending_d     = pending_q | refresh;
        byteIdx_d     = byteIdx_q;
        byte_d        = byte_q;
        charAddr_d    = charAddr_q;
        sendCommand_d = 1'b0;
        command_d     = command_q;
        cmdDelay_d    = cmdDelay_q;
        readBusy_d    = readBusy_q;
        rs_d          = rs_q;
        busy_d        = busy_q;
        frameDone_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (ready_q && pending_q) begin
                    state_d    = LOAD;
                    pending_d  = refresh;
                    busy_d     = 1'b1;
                    byteIdx_d  = 6'd0;
                    charAddr_d = 5'd0;
                end
            end
            LOAD: begin
                byte_d        = srcByte;
                rs_d          = srcIsChar;
                sendCommand_d = 1'b1;
                command_d     = srcByte[7:4];
                cmdDelay_d    = T_NIBBLE_C;
                readBusy_d    = 1'b0;
                state_d       = SEND_HI;
            end
            SEND_HI: state_d = WAIT_HI;
            WAIT_HI: begin
                if (commandDone) begin
                    sendCommand_d = 1'b1;
                    command_d     = byte_q[3:0];
                    cmdDelay_d    = T_BYTE_C;
                    readBusy_d    = 1'b1;
                    state_d       = SEND_LO;
                end
            end
            SEND_LO: state_d = WAIT_LO;
            WAIT_LO: begin
                if (commandDone) begin
                    // The last character leaves char_addr at 31 rather than wrapping.
                    if (rs_q && byteIdx_q != LAST_IDX) begin
                        charAddr_d = charAddr_q + 5'd1;
                    end
                    if (byteIdx_q == LAST_IDX) begin
                        state_d     = IDLE;
                        busy_d      = 1'b0;
                        frameDone_d = 1'b1;
                    end else begin
                        byteIdx_d = byteIdx_q + 6'd1;
                        state_d   = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q       <= IDLE;
            ready_q       <= 1'b0;
            pending_q     <= 1'b0;
            byteIdx_q     <= 6'd0;
            byte_q        <= 8'h00;
            charAddr_q    <= 5'd0;
            sendCommand_q <= 1'b0;
            command_q     <= 4'h0;
            cmdDelay_q    <= 21'd0;
            readBusy_q    <= 1'b0;
            rs_q          <= 1'b0;
            busy_q        <= 1'b0;
            frameDone_q   <= 1'b0;
            mode4bit_q    <= 1'b1;
        end else begin
            state_q       <= state_d;
            ready_q       <= ready_d;
            pending_q     <= pending_d;
            byteIdx_q     <= byteIdx_d;
            byte_q        <= byte_d;
            charAddr_q    <= charAddr_d;
            sendCommand_q <= sendCommand_d;
            command_q     <= command_d;
            cmdDelay_q    <= cmdDelay_d;
            readBusy_q    <= readBusy_d;
            rs_q          <= rs_d;
            busy_q        <= busy_d;
            frameDone_q   <= frameDone_d;
            mode4bit_q    <= 1'b1;
        end
    end

    assign char_addr    = charAddr_q;
    assign sendCommand  = sendCommand_q;
    assign command      = command_q;
    assign commandDelay = cmdDelay_q;
    assign read_busy    = readBusy_q;
    assign mode4bit     = mode4bit_q;
    assign LCD_RS       = rs_q;
    assign busy         = busy_q;
    assign frameDone    = frameDone_q;

endmodule
